ifetch_unit: RTL

//  Instruction fetch stage sitting directly upstream of the unified memory's read port. Holds the PC,

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_if.sv | 24 ++
 rtl/ifetch_fifo.sv | 51 +++++
 rtl/ifetch_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared width, state and buffer-entry types for the instruction fetch unit
package ifetch_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DRAIN = 2'd1,
      S_HALT  = 2'd2
   } ifetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } ifetch_entry_t;

   function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_pc);
      return {2'b00, byte_pc[XLEN-1:2]};
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - memory read port and decode handshake bundle of the fetch unit
interface ifetch_if;
   import ifetch_pkg::*;

   logic [XLEN-1:0] mem_rd_addr;
   logic            mem_rd_addr_valid;
   logic [XLEN-1:0] mem_rd_data;
   logic            mem_rd_ack;
   logic            instr_valid;
   logic [XLEN-1:0] instr_data;
   logic [XLEN-1:0] instr_pc;
   logic            instr_ready;

   modport master (
      output mem_rd_addr, mem_rd_addr_valid, instr_valid, instr_data, instr_pc,
      input  mem_rd_data, mem_rd_ack, instr_ready
   );

   modport slave (
      input  mem_rd_addr, mem_rd_addr_valid, instr_valid, instr_data, instr_pc,
      output mem_rd_data, mem_rd_ack, instr_ready
   );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous instruction buffer of {pc, instr} entries with flush
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  ifetch_entry_t          push_data,
   output ifetch_entry_t          head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ifetch_entry_t   mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Flush wins over a same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch stage: PC, pipelined word reads, instruction buffer, redirect flush (IFETCH_MISALIGN_CHK_EN)
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 4,
   parameter int              MAX_OUTST  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   ifetch_if.master        bus,
   output logic            fetch_fault
);

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + OW;

   ifetch_state_e   state;
   ifetch_state_e   state_next;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pcq [MAX_OUTST];
   logic [QW-1:0]   pcq_rd;
   logic [QW-1:0]   pcq_wr;
   logic [OW-1:0]   outst;
   logic [OW-1:0]   drop;
   logic [OW-1:0]   drop_next;
   logic            fault;
   logic            fault_next;
   logic            issue;
   logic            ack_live;
   logic            ack_keep;
   logic            misaligned;
   logic [XLEN-1:0] redirect_pc_eff;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   ifetch_entry_t   fifo_head;
   ifetch_entry_t   fifo_in;

`ifdef IFETCH_MISALIGN_CHK_EN
   assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redirect_pc_eff = redirect_pc;
`else
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign misaligned           = 1'b0;
   assign redirect_pc_eff      = {redirect_pc[XLEN-1:2], 2'b00};
`endif

   function automatic logic [QW-1:0] qnext(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTST - 1)) ? '0 : p + QW'(1);
   endfunction

   // An ack with nothing outstanding belongs to a pre-reset request and is ignored.
   assign ack_live   = bus.mem_rd_ack && (outst != '0);
   assign ack_keep   = ack_live && (drop == '0) && !redirect_valid;
   assign fault_next = fault | misaligned;
   assign fifo_in    = '{pc: pcq[pcq_rd], instr: bus.mem_rd_data};

   always_comb begin
      drop_next = drop;
      if (redirect_valid)
         drop_next = outst - OW'(ack_live);
      else if (ack_live && (drop != '0))
         drop_next = drop - OW'(1);
   end

   ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ack_keep),
      .pop       (bus.instr_ready && !redirect_valid),
      .flush     (redirect_valid),
      .push_data (fifo_in),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH, S_DRAIN: begin
            if (drop_next != '0)  state_next = S_DRAIN;
            else if (fault_next)  state_next = S_HALT;
            else                  state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   // Outputs are forced low while reset is held, even before the registers clear.
   always_comb begin
      issue = !reset && (state == S_FETCH) && !redirect_valid && !fifo_full &&
              (outst < OW'(MAX_OUTST)) &&
              ((SW'(fifo_count) + SW'(outst)) < SW'(FIFO_DEPTH));
      bus.mem_rd_addr_valid = issue;
      bus.mem_rd_addr       = reset ? '0 : word_addr(pc);
      bus.instr_valid       = !reset && !fifo_empty;
      bus.instr_data        = reset ? '0 : fifo_head.instr;
      bus.instr_pc          = reset ? '0 : fifo_head.pc;
      fetch_fault           = !reset && fault;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc     <= PC_RESET;
         outst  <= '0;
         drop   <= '0;
         fault  <= 1'b0;
         pcq_rd <= '0;
         pcq_wr <= '0;
      end else begin
         drop  <= drop_next;
         fault <= fault_next;
         outst <= outst + OW'(issue) - OW'(ack_live);
         if (redirect_valid) pc <= redirect_pc_eff;
         else if (issue)     pc <= pc + XLEN'(4);
         if (issue)    pcq_wr <= qnext(pcq_wr);
         if (ack_live) pcq_rd <= qnext(pcq_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (issue) pcq[pcq_wr] <= pc;
   end

endmodule
